// File: rtl/oven_cook_ctrl_if.sv
// ---------------------------------------------------------------------------
// oven_cook_ctrl_if
// Bus between the cook controller and the MM:SS countdown.
//   set_s1     preset seconds units (BCD 0..9)
//   set_s10    preset seconds tens (0..5)
//   set_m1     preset minutes units (BCD 0..9)
//   set_m10    preset minutes tens (0..5)
//   load       one-cycle pulse: countdown copies the set_* digits
//   run        countdown enabled to decrement
//   timer_done countdown reached 00:00 while running (level)
// master = controller side, slave = countdown side.
// ---------------------------------------------------------------------------
interface oven_cook_ctrl_if;
  logic [3:0] set_s1;
  logic [2:0] set_s10;
  logic [3:0] set_m1;
  logic [2:0] set_m10;
  logic       load;
  logic       run;
  logic       timer_done;

  modport master (
    output set_s1, set_s10, set_m1, set_m10, load, run,
    input  timer_done
  );

  modport slave (
    input  set_s1, set_s10, set_m1, set_m10, load, run,
    output timer_done
  );
endinterface

// File: rtl/oven_cook_ctrl.sv
// ---------------------------------------------------------------------------
// oven_cook_ctrl
// Front-panel control stage for the oven countdown timer. Synchronises the
// raw buttons and door switch, keeps the cook-time preset as BCD digits and
// sequences IDLE -> COOK <-> PAUSE -> DONE -> IDLE.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   btn_min/sec       raw buttons, increment minutes / seconds preset
//   btn_start         raw button, start (from IDLE) or resume (from PAUSE)
//   btn_cancel        raw button, cancel / clear preset
//   door_open         raw door switch, 1 = open
//   tick_1hz          one-cycle pulse per second, synchronous to clk
//   cd                countdown bus (preset digits, load, run, timer_done)
//   heater_on         heater element enable
//   beep              end-of-cook beeper
//   state             0 IDLE, 1 COOK, 2 PAUSE, 3 DONE
// All outputs come from registers or are decoded from the state register.
// ---------------------------------------------------------------------------
module oven_cook_ctrl #(
  parameter int BEEP_SECS = 3,
  parameter int MAX_MIN   = 59
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_min,
  input  logic              btn_sec,
  input  logic              btn_start,
  input  logic              btn_cancel,
  input  logic              door_open,
  input  logic              tick_1hz,
  oven_cook_ctrl_if.master  cd,
  output logic              heater_on,
  output logic              beep,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] MAX_M10   = 3'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M1    = 4'(MAX_MIN % 10);
  localparam logic [3:0] BEEP_LAST = 4'(BEEP_SECS);

  // Bit order for the conditioned inputs: 0 min, 1 sec, 2 start, 3 cancel,
  // 4 door. The door needs only the two-flop synchroniser.
  localparam int B_MIN = 0;
  localparam int B_SEC = 1;
  localparam int B_STA = 2;
  localparam int B_CAN = 3;
  localparam int B_DOOR = 4;

  logic [4:0] raw_in;
  logic [4:0] sync1_reg;
  logic [4:0] sync2_reg;
  logic [3:0] sync3_reg;
  logic [3:0] btn_edge;
  logic       door_lvl;

  state_t     state_reg, state_next;
  logic [3:0] s1_reg, s1_next;
  logic [2:0] s10_reg, s10_next;
  logic [3:0] m1_reg, m1_next;
  logic [2:0] m10_reg, m10_next;
  logic       load_reg, load_next;
  logic [3:0] beep_cnt_reg, beep_cnt_next;

  // Incremented preset values, computed once and used by the IDLE branch.
  logic [3:0] s1_inc;
  logic [2:0] s10_inc;
  logic [3:0] m1_inc;
  logic [2:0] m10_inc;
  logic [3:0] beep_cnt_inc;
  logic       preset_nz;

  assign raw_in = {door_open, btn_cancel, btn_start, btn_sec, btn_min};

  // ---------------------------------------------------------------------
  // Input conditioning: two synchroniser flops, then a third flop on the
  // buttons so a press produces a single-cycle rising-edge event.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      sync3_reg <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg[3:0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_edge
      assign btn_edge[gi] = sync2_reg[gi] & ~sync3_reg[gi];
    end
  endgenerate

  assign door_lvl = sync2_reg[B_DOOR];

  // ---------------------------------------------------------------------
  // Preset arithmetic. Seconds wrap 59 -> 00 without carrying into the
  // minutes; minutes wrap MAX_MIN -> 00.
  // ---------------------------------------------------------------------
  always_comb begin
    s1_inc  = s1_reg;
    s10_inc = s10_reg;
    if (s1_reg >= 4'd9) begin
      s1_inc  = 4'd0;
      s10_inc = (s10_reg >= 3'd5) ? 3'd0 : s10_reg + 3'd1;
    end else begin
      s1_inc = s1_reg + 4'd1;
    end
  end

  always_comb begin
    m1_inc  = m1_reg;
    m10_inc = m10_reg;
    if ((m10_reg == MAX_M10 && m1_reg >= MAX_M1) || m10_reg > MAX_M10) begin
      m1_inc  = 4'd0;
      m10_inc = 3'd0;
    end else if (m1_reg >= 4'd9) begin
      m1_inc  = 4'd0;
      m10_inc = m10_reg + 3'd1;
    end else begin
      m1_inc = m1_reg + 4'd1;
    end
  end

  assign preset_nz    = (s1_reg != 4'd0) || (s10_reg != 3'd0) ||
                        (m1_reg != 4'd0) || (m10_reg != 3'd0);
  assign beep_cnt_inc = beep_cnt_reg + 4'd1;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      s1_reg       <= '0;
      s10_reg      <= '0;
      m1_reg       <= '0;
      m10_reg      <= '0;
      load_reg     <= 1'b0;
      beep_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      s1_reg       <= s1_next;
      s10_reg      <= s10_next;
      m1_reg       <= m1_next;
      m10_reg      <= m10_next;
      load_reg     <= load_next;
      beep_cnt_reg <= beep_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic. Within each state the if/else chain encodes the
  // event priority cancel > door > timer_done > start > min/sec.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    s1_next       = s1_reg;
    s10_next      = s10_reg;
    m1_next       = m1_reg;
    m10_next      = m10_reg;
    load_next     = 1'b0;
    beep_cnt_next = beep_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (btn_edge[B_CAN]) begin
          s1_next  = '0;
          s10_next = '0;
          m1_next  = '0;
          m10_next = '0;
        end else if (btn_edge[B_STA] && preset_nz && !door_lvl) begin
          // The load pulse is registered so it is high during the first
          // COOK cycle, together with run.
          state_next = ST_COOK;
          load_next  = 1'b1;
        end else begin
          if (btn_edge[B_SEC]) begin
            s1_next  = s1_inc;
            s10_next = s10_inc;
          end
          if (btn_edge[B_MIN]) begin
            m1_next  = m1_inc;
            m10_next = m10_inc;
          end
        end
      end

      ST_COOK: begin
        if (btn_edge[B_CAN]) begin
          state_next = ST_IDLE;
        end else if (door_lvl) begin
          state_next = ST_PAUSE;
        end else if (cd.timer_done) begin
          state_next    = ST_DONE;
          beep_cnt_next = '0;
          s1_next       = '0;
          s10_next      = '0;
          m1_next       = '0;
          m10_next      = '0;
        end
      end

      ST_PAUSE: begin
        if (btn_edge[B_CAN]) begin
          state_next = ST_IDLE;
        end else if (btn_edge[B_STA] && !door_lvl) begin
          // Resume: the countdown kept its value, so no reload.
          state_next = ST_COOK;
        end
      end

      ST_DONE: begin
        if (|btn_edge) begin
          state_next = ST_IDLE;
        end else if (tick_1hz) begin
          beep_cnt_next = beep_cnt_inc;
          if (beep_cnt_inc >= BEEP_LAST) begin
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from the state register, so an asynchronous reset
  // drops run/heater immediately.
  // ---------------------------------------------------------------------
  assign cd.run     = (state_reg == ST_COOK);
  assign heater_on  = (state_reg == ST_COOK);
  assign beep       = (state_reg == ST_DONE);
  assign cd.load    = load_reg;
  assign cd.set_s1  = s1_reg;
  assign cd.set_s10 = s10_reg;
  assign cd.set_m1  = m1_reg;
  assign cd.set_m10 = m10_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_oven_cook_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oven_cook_ctrl
// Directed, table-driven bench for oven_cook_ctrl, plus hand-written
// sequences for digit wrap, cancel/timer_done collision and async reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_oven_cook_ctrl;

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_MIN  = 4'b0001;
  localparam logic [3:0] B_SEC  = 4'b0010;
  localparam logic [3:0] B_STA  = 4'b0100;
  localparam logic [3:0] B_CAN  = 4'b1000;

  localparam int IDLE  = 0;
  localparam int COOK  = 1;
  localparam int PAUSE = 2;
  localparam int DONE  = 3;

  logic       clk;
  logic       rst_n;
  logic       btn_min, btn_sec, btn_start, btn_cancel;
  logic       door_open;
  logic       tick_1hz;
  logic       heater_on;
  logic       beep;
  logic [1:0] state;

  oven_cook_ctrl_if cd_if ();

  oven_cook_ctrl #(
    .BEEP_SECS (3),
    .MAX_MIN   (59)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_min    (btn_min),
    .btn_sec    (btn_sec),
    .btn_start  (btn_start),
    .btn_cancel (btn_cancel),
    .door_open  (door_open),
    .tick_1hz   (tick_1hz),
    .cd         (cd_if),
    .heater_on  (heater_on),
    .beep       (beep),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector: pulse inputs for one cycle, hold door level, wait `settle`
  // further cycles, then compare the packed outputs.
  typedef struct {
    string       name;
    logic [3:0]  btn;     // {cancel, start, sec, min}
    logic        door;
    logic        tdone;
    logic        tick;
    int          settle;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   tests_run;
  int   tests_failed;

  // Expected output word: {state, m10, m1, s10, s1, load, run, heater, beep}
  function automatic logic [19:0] ex(int st, int m, int s,
                                     logic ld, logic rn, logic ht, logic bp);
    return {2'(st), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10),
            ld, rn, ht, bp};
  endfunction

  function automatic logic [19:0] dut_word();
    return {state, cd_if.set_m10, cd_if.set_m1, cd_if.set_s10, cd_if.set_s1,
            cd_if.load, cd_if.run, heater_on, beep};
  endfunction

  function automatic vec_t mk(string nm, logic [3:0] b, logic d, logic td,
                              logic tk, int st, logic [19:0] e);
    vec_t v;
    v.name = nm; v.btn = b; v.door = d; v.tdone = td; v.tick = tk;
    v.settle = st; v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [19:0] exp);
    logic [19:0] act;
    act = dut_word();
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got st=%0d %0d%0d:%0d%0d ld=%0b run=%0b ht=%0b bp=%0b, want st=%0d %0d%0d:%0d%0d ld=%0b run=%0b ht=%0b bp=%0b",
               nm, act[19:18], act[17:15], act[14:11], act[10:8], act[7:4],
               act[3], act[2], act[1], act[0],
               exp[19:18], exp[17:15], exp[14:11], exp[10:8], exp[7:4],
               exp[3], exp[2], exp[1], exp[0]);
    end else begin
      $display("[TB] ok   %s: st=%0d %0d%0d:%0d%0d ld=%0b run=%0b ht=%0b bp=%0b",
               nm, act[19:18], act[17:15], act[14:11], act[10:8], act[7:4],
               act[3], act[2], act[1], act[0]);
    end
  endtask

  task automatic drive_btn(input logic [3:0] b);
    btn_min    = b[0];
    btn_sec    = b[1];
    btn_start  = b[2];
    btn_cancel = b[3];
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive_btn(v.btn);
    door_open         = v.door;
    cd_if.timer_done  = v.tdone;
    tick_1hz          = v.tick;
    @(negedge clk);
    drive_btn(B_NONE);
    cd_if.timer_done  = 1'b0;
    tick_1hz          = 1'b0;
    repeat (v.settle) @(negedge clk);
    check(v.name, v.exp);
  endtask

  // A press sampled at edge k acts at edge k+2; return just after that.
  task automatic press(input logic [3:0] b);
    @(negedge clk);
    drive_btn(b);
    @(negedge clk);
    drive_btn(B_NONE);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive_btn(B_NONE);
    door_open        = 1'b0;
    tick_1hz         = 1'b0;
    cd_if.timer_done = 1'b0;

    // Main table; door stays at the level of the last vector.
    vecs.push_back(mk("sec_1",        B_SEC,  0, 0, 0, 2, ex(IDLE,  0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk("sec_2",        B_SEC,  0, 0, 0, 2, ex(IDLE,  0, 2, 0, 0, 0, 0)));
    vecs.push_back(mk("sec_3",        B_SEC,  0, 0, 0, 2, ex(IDLE,  0, 3, 0, 0, 0, 0)));
    vecs.push_back(mk("min_1",        B_MIN,  0, 0, 0, 2, ex(IDLE,  1, 3, 0, 0, 0, 0)));
    vecs.push_back(mk("min_2",        B_MIN,  0, 0, 0, 2, ex(IDLE,  2, 3, 0, 0, 0, 0)));
    vecs.push_back(mk("start_load",   B_STA,  0, 0, 0, 2, ex(COOK,  2, 3, 1, 1, 1, 0)));
    vecs.push_back(mk("load_drops",   B_NONE, 0, 0, 0, 0, ex(COOK,  2, 3, 0, 1, 1, 0)));
    vecs.push_back(mk("min_in_cook",  B_MIN,  0, 0, 0, 2, ex(COOK,  2, 3, 0, 1, 1, 0)));
    vecs.push_back(mk("door_pause",   B_NONE, 1, 0, 0, 2, ex(PAUSE, 2, 3, 0, 0, 0, 0)));
    vecs.push_back(mk("start_door_op",B_STA,  1, 0, 0, 2, ex(PAUSE, 2, 3, 0, 0, 0, 0)));
    vecs.push_back(mk("door_close",   B_NONE, 0, 0, 0, 2, ex(PAUSE, 2, 3, 0, 0, 0, 0)));
    vecs.push_back(mk("resume_noload",B_STA,  0, 0, 0, 2, ex(COOK,  2, 3, 0, 1, 1, 0)));
    vecs.push_back(mk("done_entry",   B_NONE, 0, 1, 1, 0, ex(DONE,  0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk("tick_1",       B_NONE, 0, 0, 1, 0, ex(DONE,  0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk("tick_2",       B_NONE, 0, 0, 1, 0, ex(DONE,  0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk("tick_3_idle",  B_NONE, 0, 0, 1, 0, ex(IDLE,  0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("min_a",        B_MIN,  0, 0, 0, 2, ex(IDLE,  1, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("start_b",      B_STA,  0, 0, 0, 2, ex(COOK,  1, 0, 1, 1, 1, 0)));
    vecs.push_back(mk("done_b",       B_NONE, 0, 1, 0, 0, ex(DONE,  0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk("min_ends_done",B_MIN,  0, 0, 0, 2, ex(IDLE,  0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("sec_c",        B_SEC,  0, 0, 0, 2, ex(IDLE,  0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk("cancel_clear", B_CAN,  0, 0, 0, 2, ex(IDLE,  0, 0, 0, 0, 0, 0)));

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_state", ex(IDLE, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) apply(vecs[i]);

    // Seconds wrap 59 -> 00 with minutes untouched
    for (int i = 0; i < 59; i++) press(B_SEC);
    check("sec_to_59", ex(IDLE, 0, 59, 0, 0, 0, 0));
    press(B_SEC);
    check("sec_wrap", ex(IDLE, 0, 0, 0, 0, 0, 0));

    // Minutes wrap MAX_MIN -> 00
    for (int i = 0; i < 59; i++) press(B_MIN);
    check("min_to_59", ex(IDLE, 59, 0, 0, 0, 0, 0));
    press(B_MIN);
    check("min_wrap", ex(IDLE, 0, 0, 0, 0, 0, 0));

    // Start with a 00:00 preset is ignored
    press(B_STA);
    check("start_zero", ex(IDLE, 0, 0, 0, 0, 0, 0));

    // Cancel edge and timer_done in the same cycle: cancel wins
    press(B_SEC);
    press(B_STA);
    check("start_c", ex(COOK, 0, 1, 1, 1, 1, 0));
    @(negedge clk);
    btn_cancel = 1'b1;
    @(negedge clk);
    btn_cancel = 1'b0;
    @(negedge clk);
    cd_if.timer_done = 1'b1;
    @(negedge clk);
    cd_if.timer_done = 1'b0;
    check("cancel_beats_done", ex(IDLE, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    check("no_beep_after", ex(IDLE, 0, 1, 0, 0, 0, 0));

    // Asynchronous reset in the middle of COOK
    press(B_STA);
    check("start_d", ex(COOK, 0, 1, 1, 1, 1, 0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", ex(IDLE, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after_reset", ex(IDLE, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
